gate_motor_sequencer: RTL and testbench
=======================================

// Module: gate_motor_sequencer
// PURPOSE
//  Sequences the gate motor from one push-button and three sensors: open/closed limit
//  switches and an obstacle sensor. Drives mutually exclusive open/close motor enables with
//  dead time, travel timeout and obstacle reversal. Reports state on HEX0, LEDG and LEDR.
//  Sits between board I/O and the motor driver; it replaces manual motor switching.
// PARAMETERS
//  DEBOUNCE_CYCLES    540000     stable KEY cycles before a press is accepted (20 ms @27 MHz)
//  DEAD_CYCLES        2700       motor-off cycles on every entry to OPENING/CLOSING (100 us)
//  TRAVEL_TIMEOUT     270000000  max cycles in OPENING/CLOSING before FAULT (10 s)
//  AUTO_CLOSE_CYCLES  135000000  cycles in OPEN before auto close (5 s; only with macro)
// PORTS
//  CLOCK_27      in   1  27 MHz board clock; all logic on its rising edge
//  RESET         in   1  synchronous, active-high reset
//  KEY_N         in   1  gate push-button, active low, asynchronous
//  LIMIT_OPEN    in   1  1 = gate fully open, asynchronous
//  LIMIT_CLOSED  in   1  1 = gate fully closed, asynchronous
//  OBSTACLE      in   1  1 = obstacle in gate path, asynchronous
//  MOTOR_OPEN    out  1  motor drive, opening direction
//  MOTOR_CLOSE   out  1  motor drive, closing direction
//  STATE         out  3  current state code
//  FAULT         out  1  1 while in FAULT
//  HEX0          out  7  7-segment display, active low, {g,f,e,d,c,b,a}
//  LEDG          out  1  equals MOTOR_OPEN
//  LEDR          out  1  equals MOTOR_CLOSE
// BEHAVIOUR
//  - All four asynchronous inputs pass through a 2-flop synchronizer before use.
//  - Debounce: a press is accepted after synchronized KEY_N has been stable for DEBOUNCE_CYCLES.
//    Each accepted 1->0 transition makes a one-cycle PRESS pulse. A held key gives one pulse only.
//  - States and codes: CLOSED=0, OPENING=1, OPEN=2, CLOSING=3, STOP_O=4, STOP_C=5, FAULT=6.
//    Code 7 is illegal and goes to FAULT.
//  - Transitions, one cycle after the qualifying synchronized input. Priority is left to right:
//    CLOSED : PRESS -> OPENING
//    OPENING: LIMIT_OPEN -> OPEN; timeout -> FAULT; PRESS -> STOP_O
//    OPEN   : PRESS -> CLOSING; auto-close expiry -> CLOSING (macro only)
//    CLOSING: LIMIT_CLOSED -> CLOSED; OBSTACLE -> OPENING; timeout -> FAULT; PRESS -> STOP_C
//    STOP_O : PRESS -> CLOSING      STOP_C : PRESS -> OPENING
//    FAULT  : no exit except RESET
//  - Any state except FAULT: LIMIT_OPEN and LIMIT_CLOSED both 1 -> FAULT. This rule has
//    the highest priority.
//  - Entry to OPENING or CLOSING, including obstacle reversal:
//    dead counter loads DEAD_CYCLES and travel counter clears.
//    Motor outputs stay 0 until the dead counter reaches 0.
//    Then MOTOR_OPEN=1 (OPENING) or MOTOR_CLOSE=1 (CLOSING).
//  - Travel counter counts every cycle in OPENING/CLOSING, dead time included.
//    Timeout fires when the count reaches TRAVEL_TIMEOUT-1. Counters saturate and never wrap.
//  - MOTOR_OPEN and MOTOR_CLOSE are registered and never both 1.
//    Both are 0 in CLOSED, OPEN, STOP_O, STOP_C and FAULT.
//  - HEX0 by state: CLOSED 0001110 "F"; OPEN 0001000 "A"; OPENING/CLOSING 0111111 "-";
//    STOP_O/STOP_C 0010010 "S"; FAULT 0000110 "E".
//  - RESET at any time, mid-travel included:
//    state=CLOSED, STATE=0, MOTOR_OPEN=MOTOR_CLOSE=0, FAULT=0, HEX0=0001110.
//    All counters and synchronizers clear. Debounce assumes KEY_N released (1).
//  - The reset state is CLOSED regardless of the limit inputs.
// CONFIGURATION
//  GATE_AUTO_CLOSE_EN defined:
//    in OPEN an auto-close counter runs. It is held at 0 while synchronized OBSTACLE=1.
//    Expiry after AUTO_CLOSE_CYCLES -> CLOSING. The counter clears on leaving OPEN.
//  Not defined: no auto-close counter is built; OPEN leaves only on PRESS or the limit fault.
// TESTING  (DEBOUNCE_CYCLES=4, DEAD_CYCLES=2, TRAVEL_TIMEOUT=50, AUTO_CLOSE_CYCLES=20)
//  1 Reset, then KEY_N low 10 cycles -> one PRESS. STATE 0->1.
//    MOTOR_OPEN=1 exactly 2 cycles after entry.
//    LIMIT_OPEN=1 -> STATE=2, motors 0, HEX0=0001000.
//  2 KEY_N bouncing 1-0-1-0 at 1-cycle intervals, then low 10 cycles -> exactly one PRESS.
//  3 CLOSING with MOTOR_CLOSE=1, OBSTACLE=1 -> STATE=1.
//    Both motors 0 for 2 cycles, then MOTOR_OPEN=1. At no cycle are both 1.
//  4 OPENING, no limit for 50 cycles -> STATE=6, FAULT=1, HEX0=0000110.
//    PRESS has no effect. RESET -> STATE=0.
//  5 In OPEN, LIMIT_CLOSED=1 with LIMIT_OPEN=1 -> STATE=6 next cycle.
//    Separately, RESET during OPENING -> next cycle STATE=0, motors 0.
//  6 GATE_AUTO_CLOSE_EN defined: OPEN idle 20 cycles -> STATE=3.
//    OBSTACLE=1 held in OPEN -> remains OPEN. Macro undefined -> OPEN idle 200 cycles, still 2.

Source files
------------

// File: rtl/gate_motor_sequencer.sv
// Gate motor sequencer: one push-button plus limit/obstacle sensors drive interlocked
// open/close motor enables with dead time, travel timeout and obstacle reversal.
// Auto-close in OPEN is built only when GATE_AUTO_CLOSE_EN is defined.
module gate_motor_sequencer #(
  parameter int DEBOUNCE_CYCLES   = 540000,
  parameter int DEAD_CYCLES       = 2700,
  parameter int TRAVEL_TIMEOUT    = 270000000,
  parameter int AUTO_CLOSE_CYCLES = 135000000
) (
  input  logic       CLOCK_27,
  input  logic       RESET,
  input  logic       KEY_N,
  input  logic       LIMIT_OPEN,
  input  logic       LIMIT_CLOSED,
  input  logic       OBSTACLE,
  output logic       MOTOR_OPEN,
  output logic       MOTOR_CLOSE,
  output logic [2:0] STATE,
  output logic       FAULT,
  output logic [6:0] HEX0,
  output logic       LEDG,
  output logic       LEDR
);
  localparam int DBW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW  = (DEAD_CYCLES < 1) ? 1 : $clog2(DEAD_CYCLES + 1);
  localparam int TW  = (TRAVEL_TIMEOUT < 2) ? 1 : $clog2(TRAVEL_TIMEOUT + 1);
  localparam logic [DBW-1:0] DB_LAST     = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0]  DEAD_LOAD   = DW'(DEAD_CYCLES);
  localparam logic [TW-1:0]  TRAVEL_LAST = TW'(TRAVEL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_CLOSED  = 3'd0,
    S_OPENING = 3'd1,
    S_OPEN    = 3'd2,
    S_CLOSING = 3'd3,
    S_STOP_O  = 3'd4,
    S_STOP_C  = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  logic [1:0]     r_key_sync, r_lo_sync, r_lc_sync, r_obs_sync;
  logic           r_key_stable, r_press;
  logic [DBW-1:0] r_db_cnt;
  logic [DW-1:0]  r_dead, w_dead_nxt;
  logic [TW-1:0]  r_travel;
  logic           r_motor_open, r_motor_close;
  state_t         r_state, w_next;
  logic           w_key, w_lo, w_lc, w_obs;
  logic           w_travel_st, w_enter, w_timeout, w_auto_expire;

  // Two-flop synchronizers; KEY_N idles released
  always_ff @(posedge CLOCK_27) begin
    if (RESET) begin
      r_key_sync <= 2'b11;
      r_lo_sync  <= 2'b00;
      r_lc_sync  <= 2'b00;
      r_obs_sync <= 2'b00;
    end else begin
      r_key_sync <= {r_key_sync[0], KEY_N};
      r_lo_sync  <= {r_lo_sync[0], LIMIT_OPEN};
      r_lc_sync  <= {r_lc_sync[0], LIMIT_CLOSED};
      r_obs_sync <= {r_obs_sync[0], OBSTACLE};
    end
  end

  assign w_key = r_key_sync[1];
  assign w_lo  = r_lo_sync[1];
  assign w_lc  = r_lc_sync[1];
  assign w_obs = r_obs_sync[1];

  // Debounce: a level is accepted once it differs from the stable level for DEBOUNCE_CYCLES
  always_ff @(posedge CLOCK_27) begin
    if (RESET) begin
      r_key_stable <= 1'b1;
      r_db_cnt     <= '0;
      r_press      <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (w_key == r_key_stable) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_key_stable <= w_key;
        r_db_cnt     <= '0;
        r_press      <= ~w_key;
      end else begin
        r_db_cnt <= r_db_cnt + DBW'(1);
      end
    end
  end

`ifdef GATE_AUTO_CLOSE_EN
  localparam int AW = (AUTO_CLOSE_CYCLES < 2) ? 1 : $clog2(AUTO_CLOSE_CYCLES + 1);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_CLOSE_CYCLES - 1);
  logic [AW-1:0] r_auto;

  always_ff @(posedge CLOCK_27) begin
    if (RESET || r_state != S_OPEN || w_obs) begin
      r_auto <= '0;
    end else if (r_auto != '1) begin
      r_auto <= r_auto + AW'(1);
    end
  end

  assign w_auto_expire = (r_state == S_OPEN) && !w_obs && (r_auto == AUTO_LAST);
`else
  assign w_auto_expire = 1'b0;
`endif

  assign w_travel_st = (r_state == S_OPENING) || (r_state == S_CLOSING);
  assign w_timeout   = (r_travel == TRAVEL_LAST);

  always_comb begin
    w_next = r_state;
    if (r_state != S_FAULT && w_lo && w_lc) begin
      w_next = S_FAULT;
    end else begin
      case (r_state)
        S_CLOSED:  if (r_press) w_next = S_OPENING;
        S_OPENING: begin
          if (w_lo)           w_next = S_OPEN;
          else if (w_timeout) w_next = S_FAULT;
          else if (r_press)   w_next = S_STOP_O;
        end
        S_OPEN: begin
          if (r_press)            w_next = S_CLOSING;
          else if (w_auto_expire) w_next = S_CLOSING;
        end
        S_CLOSING: begin
          if (w_lc)           w_next = S_CLOSED;
          else if (w_obs)     w_next = S_OPENING;
          else if (w_timeout) w_next = S_FAULT;
          else if (r_press)   w_next = S_STOP_C;
        end
        S_STOP_O:  if (r_press) w_next = S_CLOSING;
        S_STOP_C:  if (r_press) w_next = S_OPENING;
        S_FAULT:   w_next = S_FAULT;
        default:   w_next = S_FAULT;
      endcase
    end
  end

  // Any entry into a travel state, reversal included, restarts dead time and travel time
  assign w_enter = ((w_next == S_OPENING) || (w_next == S_CLOSING)) && (w_next != r_state);

  always_comb begin
    w_dead_nxt = '0;
    if (w_enter)                        w_dead_nxt = DEAD_LOAD;
    else if (w_travel_st && r_dead != '0) w_dead_nxt = r_dead - DW'(1);
  end

  always_ff @(posedge CLOCK_27) begin
    if (RESET) begin
      r_state       <= S_CLOSED;
      r_dead        <= '0;
      r_travel      <= '0;
      r_motor_open  <= 1'b0;
      r_motor_close <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_dead        <= w_dead_nxt;
      r_motor_open  <= (w_next == S_OPENING) && (w_dead_nxt == '0);
      r_motor_close <= (w_next == S_CLOSING) && (w_dead_nxt == '0);
      if (w_enter || !w_travel_st) r_travel <= '0;
      else if (r_travel != '1)     r_travel <= r_travel + TW'(1);
    end
  end

  always_comb begin
    case (r_state)
      S_CLOSED:            HEX0 = 7'b0001110;
      S_OPEN:              HEX0 = 7'b0001000;
      S_OPENING, S_CLOSING: HEX0 = 7'b0111111;
      S_STOP_O, S_STOP_C:  HEX0 = 7'b0010010;
      default:             HEX0 = 7'b0000110;
    endcase
  end

  assign STATE       = r_state;
  assign FAULT       = (r_state == S_FAULT);
  assign MOTOR_OPEN  = r_motor_open;
  assign MOTOR_CLOSE = r_motor_close;
  assign LEDG        = r_motor_open;
  assign LEDR        = r_motor_close;
endmodule

// File: tb/tb_gate_motor_sequencer.sv
// Bench for gate_motor_sequencer: scripted vector table, a bounce sequence and a random
// run, all shadowed cycle by cycle by a timestamp-based model of the gate's rules.
module tb_gate_motor_sequencer;
  localparam int DB = 4, DEAD = 2, TT = 50, AC = 20;
`ifdef GATE_AUTO_CLOSE_EN
  localparam bit AUTO_ON = 1'b1;
  localparam int AC_ST = 3, AC_LONG = 6;
`else
  localparam bit AUTO_ON = 1'b0;
  localparam int AC_ST = 2, AC_LONG = 2;
`endif

  logic clk = 1'b0;
  logic rst, key_n, lim_o, lim_c, obs;
  logic mo, mc, fault, ledg, ledr;
  logic [2:0] st;
  logic [6:0] hex;

  always #5 clk = ~clk;

  gate_motor_sequencer #(
    .DEBOUNCE_CYCLES(DB), .DEAD_CYCLES(DEAD), .TRAVEL_TIMEOUT(TT), .AUTO_CLOSE_CYCLES(AC)
  ) dut (
    .CLOCK_27(clk), .RESET(rst), .KEY_N(key_n), .LIMIT_OPEN(lim_o), .LIMIT_CLOSED(lim_c),
    .OBSTACLE(obs), .MOTOR_OPEN(mo), .MOTOR_CLOSE(mc), .STATE(st), .FAULT(fault),
    .HEX0(hex), .LEDG(ledg), .LEDR(ledr)
  );

  int checks = 0, failures = 0;

  // Reference model: states by code, travel timing from the entry timestamp
  int m_t, m_state, m_entry, m_quiet;
  bit m_press, m_lvl, m_mo, m_mc;
  bit m_s1[4], m_s2[4];
  bit m_khist[$];

  function automatic logic [6:0] hex_of(int s);
    case (s)
      0:       return 7'b0001110;
      2:       return 7'b0001000;
      1, 3:    return 7'b0111111;
      4, 5:    return 7'b0010010;
      default: return 7'b0000110;
    endcase
  endfunction

  task automatic model_edge();
    int nxt;
    bit u_key, u_lo, u_lc, u_obs, all_diff;
    m_t++;
    if (rst) begin
      m_state = 0; m_entry = 0; m_quiet = 0; m_press = 0; m_lvl = 1;
      m_mo = 0; m_mc = 0; m_khist.delete();
      m_s1 = '{1'b1, 1'b0, 1'b0, 1'b0};
      m_s2 = '{1'b1, 1'b0, 1'b0, 1'b0};
      return;
    end
    u_key = m_s2[0]; u_lo = m_s2[1]; u_lc = m_s2[2]; u_obs = m_s2[3];
    nxt = m_state;
    if (m_state != 6 && u_lo && u_lc) nxt = 6;
    else begin
      case (m_state)
        0: if (m_press) nxt = 1;
        1: if (u_lo) nxt = 2; else if (m_t - m_entry == TT) nxt = 6; else if (m_press) nxt = 4;
        2: if (m_press) nxt = 3; else if (AUTO_ON && !u_obs && m_quiet == AC - 1) nxt = 3;
        3: if (u_lc) nxt = 0; else if (u_obs) nxt = 1;
           else if (m_t - m_entry == TT) nxt = 6; else if (m_press) nxt = 5;
        4: if (m_press) nxt = 3;
        5: if (m_press) nxt = 1;
        default: nxt = 6;
      endcase
    end
    m_quiet = (m_state == 2 && !u_obs) ? m_quiet + 1 : 0;
    if ((nxt == 1 || nxt == 3) && nxt != m_state) m_entry = m_t;
    m_mo = (nxt == 1) && (m_t - m_entry >= DEAD);
    m_mc = (nxt == 3) && (m_t - m_entry >= DEAD);
    m_state = nxt;
    m_khist.push_back(u_key);
    if (m_khist.size() > DB) void'(m_khist.pop_front());
    m_press = 0;
    if (m_khist.size() == DB) begin
      all_diff = 1;
      foreach (m_khist[i]) if (m_khist[i] == m_lvl) all_diff = 0;
      if (all_diff) begin
        m_lvl = !m_lvl;
        m_press = !m_lvl;
      end
    end
    m_s2 = m_s1;
    m_s1 = '{key_n, lim_o, lim_c, obs};
  endtask

  task automatic check_model();
    checks++;
    if (st !== 3'(m_state) || mo !== m_mo || mc !== m_mc || fault !== (m_state == 6) ||
        hex !== hex_of(m_state) || ledg !== m_mo || ledr !== m_mc || (mo && mc)) begin
      failures++;
      if (failures <= 30)
        $display("FAIL model t=%0d: got state=%0d mo=%b mc=%b fault=%b hex=%b ledg=%b ledr=%b, want state=%0d mo=%b mc=%b hex=%b",
                 m_t, st, mo, mc, fault, hex, ledg, ledr, m_state, m_mo, m_mc, hex_of(m_state));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic hand_check(input string name, input int es, input bit emo, input bit emc);
    checks++;
    if (st !== 3'(es) || mo !== emo || mc !== emc || hex !== hex_of(es) || fault !== (es == 6)) begin
      failures++;
      $display("FAIL %s: got state=%0d mo=%b mc=%b hex=%b, want state=%0d mo=%b mc=%b hex=%b",
               name, st, mo, mc, hex, es, emo, emc, hex_of(es));
    end
  endtask

  typedef struct {
    bit rst, key, lo, lc, obs;
    int hold;
    int est;
    bit emo, emc;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit k, bit lo, bit lc, bit ob, int h, int es, bit emo, bit emc);
    vec_t v;
    v.rst = r; v.key = k; v.lo = lo; v.lc = lc; v.obs = ob;
    v.hold = h; v.est = es; v.emo = emo; v.emc = emc;
    return v;
  endfunction

  initial begin
    rst = 1; key_n = 1; lim_o = 0; lim_c = 0; obs = 0;
    //                rst key lo lc ob hold  state   mo mc
    vecs.push_back(mk(1, 1, 0, 0, 0,   2, 0,       0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   6, 0,       0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 1,       0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 1,       0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 1,       1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,   2, 1,       1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,   1, 2,       0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,   4, 2,       0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   6, 2,       0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   1, 3,       0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   2, 3,       0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 1,   2, 3,       0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 1,   1, 1,       0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,   1, 1,       0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,   1, 1,       1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,  47, 1,       1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,   1, 6,       0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  12, 6,       0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,   1, 0,       0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   7, 1,       0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   2, 1,       1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,   1, 0,       0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   7, 1,       0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,   3, 2,       0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0,   2, 2,       0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0,   1, 6,       0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0,   2, 0,       0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,   3, 0,       0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,   7, 1,       0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,   3, 2,       0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1,  30, 2,       0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,  20, 2,       0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,   1, 2,       0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0,   1, AC_ST,   0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 200, AC_LONG, 0, 0));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; key_n = vecs[i].key; lim_o = vecs[i].lo;
      lim_c = vecs[i].lc; obs = vecs[i].obs;
      repeat (vecs[i].hold) step();
      hand_check($sformatf("vec%0d", i), vecs[i].est, vecs[i].emo, vecs[i].emc);
    end

    // Bouncing key 1-0-1-0 then held low: exactly one press, so OPENING and never STOP_O
    rst = 1; key_n = 1; lim_o = 0; lim_c = 0; obs = 0;
    step(); step();
    rst = 0;
    key_n = 1; step();
    key_n = 0; step();
    key_n = 1; step();
    key_n = 0; step();
    repeat (5) step();
    hand_check("bounce_pre", 0, 0, 0);
    step();
    hand_check("bounce_press", 1, 0, 0);
    repeat (2) step();
    hand_check("bounce_motor", 1, 1, 0);
    repeat (20) step();
    hand_check("bounce_held", 1, 1, 0);

    // Random run against the model
    rst = 1; key_n = 1; lim_o = 0; lim_c = 0; obs = 0;
    step(); step();
    rst = 0;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0)  key_n = ~key_n;
      if ($urandom_range(0, 24) == 0) lim_o = ~lim_o;
      if ($urandom_range(0, 24) == 0) lim_c = ~lim_c;
      if ($urandom_range(0, 19) == 0) obs = ~obs;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
